// File: rtl/wr_bank_dir_arb.sv
// wr_bank_dir_arb: round-robin merge of the four direction write streams of one hash bank into a FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled by defining WR_BANK_DIR_ARB_BYPASS_EN.
module wr_bank_dir_arb #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 1024,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TXNID_W = 8,
    parameter int SB_W    = 8,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   in_vld,
    output logic [3:0]                   in_rdy,
    input  logic [3:0][ADDR_W-1:0]       in_addr,
    input  logic [3:0][TXNID_W-1:0]      in_txnid,
    input  logic [3:0][SB_W-1:0]         in_sideband,
    input  logic [3:0][STRB_W-1:0]       in_strb,
    input  logic [3:0][DATA_W-1:0]       in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [TXNID_W-1:0]           out_txnid,
    output logic [SB_W-1:0]              out_sideband,
    output logic [STRB_W-1:0]            out_strb,
    output logic [DATA_W-1:0]            out_data,
    output logic [1:0]                   out_src_dir,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [1:0]         dir;
        logic [ADDR_W-1:0]  addr;
        logic [TXNID_W-1:0] txnid;
        logic [SB_W-1:0]    sideband;
        logic [STRB_W-1:0]  strb;
        logic [DATA_W-1:0]  data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           sel;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       rr_ptr;
    logic [1:0]       gnt_idx;
    logic [3:0]       grant;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             accept;
    logic             push;
    logic             pop;

    assign empty = (fifo_cnt == '0);
    assign full  = (fifo_cnt == CNT_W'(DEPTH));

    // Scan from rr_ptr upward; the first valid direction wins.
    always_comb begin
        // NOTE: every comb output gets a default before any conditional, so no latch is inferred.
        logic       found;
        logic [1:0] cand;
        found   = 1'b0;
        cand    = rr_ptr;
        gnt_idx = rr_ptr;
        grant   = '0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && in_vld[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found) grant[gnt_idx] = 1'b1;
    end

    assign in_rdy = grant & {4{~full & ~rst}};
    assign accept = |(in_vld & in_rdy);
    assign push   = accept & ~bypass;
    assign pop    = ~empty & out_rdy;

    always_comb begin
        sel.dir      = gnt_idx;
        sel.addr     = in_addr[gnt_idx];
        sel.txnid    = in_txnid[gnt_idx];
        sel.sideband = in_sideband[gnt_idx];
        sel.strb     = in_strb[gnt_idx];
        sel.data     = in_data[gnt_idx];
    end

`ifdef WR_BANK_DIR_ARB_BYPASS_EN
    // Empty FIFO and a ready sink: the granted request skips storage entirely.
    assign bypass  = empty & out_rdy & ~rst;
    assign head    = bypass ? sel : mem[rd_ptr];
    assign out_vld = ~empty | (bypass & |in_vld);
`else
    assign bypass  = 1'b0;
    assign head    = mem[rd_ptr];
    assign out_vld = ~empty;
`endif

    assign out_addr     = head.addr;
    assign out_txnid    = head.txnid;
    assign out_sideband = head.sideband;
    assign out_strb     = head.strb;
    assign out_data     = head.data;
    assign out_src_dir  = head.dir;

    // NOTE: payload storage has no reset; out_vld qualifies it, and resetting 1 kb entries costs flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sel;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept) rr_ptr <= gnt_idx + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_bank_dir_arb.sv
// Self-checking bench for wr_bank_dir_arb: directed vector table, hand sequences, and randomized
// traffic compared against a queue-based reference model.
module tb_wr_bank_dir_arb;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 1024;
    localparam int STRB_W  = 128;
    localparam int TXNID_W = 8;
    localparam int SB_W    = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH+1);
`ifdef WR_BANK_DIR_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [3:0]                 in_vld = '0;
    logic [3:0]                 in_rdy;
    logic [3:0][ADDR_W-1:0]     in_addr = '0;
    logic [3:0][TXNID_W-1:0]    in_txnid = '0;
    logic [3:0][SB_W-1:0]       in_sideband = '0;
    logic [3:0][STRB_W-1:0]     in_strb = '0;
    logic [3:0][DATA_W-1:0]     in_data = '0;
    logic                       out_vld;
    logic                       out_rdy = 1'b0;
    logic [ADDR_W-1:0]          out_addr;
    logic [TXNID_W-1:0]         out_txnid;
    logic [SB_W-1:0]            out_sideband;
    logic [STRB_W-1:0]          out_strb;
    logic [DATA_W-1:0]          out_data;
    logic [1:0]                 out_src_dir;
    logic [CNT_W-1:0]           fifo_cnt;

    always #5 clk = ~clk;

    wr_bank_dir_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W),
        .TXNID_W(TXNID_W), .SB_W(SB_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_addr(in_addr), .in_txnid(in_txnid), .in_sideband(in_sideband),
        .in_strb(in_strb), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_addr(out_addr), .out_txnid(out_txnid), .out_sideband(out_sideband),
        .out_strb(out_strb), .out_data(out_data), .out_src_dir(out_src_dir),
        .fifo_cnt(fifo_cnt)
    );

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [TXNID_W-1:0] txnid;
        logic [SB_W-1:0]    sb;
        logic [STRB_W-1:0]  strb;
        logic [DATA_W-1:0]  data;
        int                 dir;
    } ent_t;

    typedef struct {
        bit         rst;
        logic [3:0] vld;
        bit         ordy;
        logic [3:0] exp_rdy;
        bit         exp_ov;
        int         exp_cnt;
        int         exp_dir;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    ent_t       req [4];
    logic [3:0] vld = '0;
    ent_t       q [$];
    int         rr = 0;
    vec_t       tbl [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got low128 %h expected low128 %h at %0t", name, act[127:0], exp[127:0], $time);
        end
    endtask

    task automatic new_req(input int i);
        req[i].addr  = {$urandom, $urandom};
        req[i].txnid = TXNID_W'($urandom);
        req[i].sb    = SB_W'($urandom);
        for (int w = 0; w < STRB_W / 32; w++) req[i].strb[w*32 +: 32] = $urandom;
        for (int w = 0; w < DATA_W / 32; w++) req[i].data[w*32 +: 32] = $urandom;
        req[i].dir = i;
        vld[i] = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_vld[i]      = vld[i];
            in_addr[i]     = req[i].addr;
            in_txnid[i]    = req[i].txnid;
            in_sideband[i] = req[i].sb;
            in_strb[i]     = req[i].strb;
            in_data[i]     = req[i].data;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = '0;
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        rr = 0;
    endtask

    // One clock of the reference model: expectations from the round-robin/queue rules, then update.
    task automatic model_cycle();
        int         g;
        bit         found;
        bit         byp;
        bit         exp_ov;
        logic [3:0] exp_rdy;
        ent_t       head;
        drive();
        found = 1'b0;
        g = 0;
        for (int k = 0; k < 4; k++)
            if (!found && vld[(rr + k) % 4]) begin
                found = 1'b1;
                g = (rr + k) % 4;
            end
        byp     = BYP && (q.size() == 0) && out_rdy;
        exp_rdy = (found && q.size() < DEPTH) ? 4'(1 << g) : 4'b0000;
        exp_ov  = (q.size() != 0) || (byp && found);
        head    = (q.size() != 0) ? q[0] : req[g];
        #1;
        check("in_rdy", in_rdy, exp_rdy);
        check("out_vld", out_vld, exp_ov);
        check("fifo_cnt", fifo_cnt, q.size());
        if (exp_ov) begin
            check("out_addr", out_addr, head.addr);
            check("out_txnid", out_txnid, head.txnid);
            check("out_sideband", out_sideband, head.sb);
            check("out_strb", out_strb, head.strb);
            check("out_src_dir", out_src_dir, head.dir);
            check_data("out_data", out_data, head.data);
        end
        @(posedge clk);
        if (q.size() != 0 && out_rdy) void'(q.pop_front());
        if (exp_rdy != 0) begin
            if (!byp) q.push_back(req[g]);
            rr = (g + 1) % 4;
            vld[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        // rst, vld, out_rdy, exp in_rdy, exp out_vld, exp fifo_cnt, exp out_src_dir
        tbl.push_back('{0, 4'b0000, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{0, 4'b0000, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{0, 4'b0001, 1, 4'b0001, 0, 0, 0});
        tbl.push_back('{0, 4'b0000, 1, 4'b0000, 1, 1, 0});
        tbl.push_back('{0, 4'b0000, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{1, 4'b0000, 1, 4'b0000, 0, 0, 0});
        tbl.push_back('{0, 4'b1111, 1, 4'b0001, 0, 0, 0});
        tbl.push_back('{0, 4'b1111, 1, 4'b0010, 1, 1, 0});
        tbl.push_back('{0, 4'b1111, 1, 4'b0100, 1, 1, 1});
        tbl.push_back('{0, 4'b1111, 1, 4'b1000, 1, 1, 2});
        tbl.push_back('{0, 4'b1111, 1, 4'b0001, 1, 1, 3});
        tbl.push_back('{0, 4'b1111, 1, 4'b0010, 1, 1, 0});
        tbl.push_back('{0, 4'b1111, 1, 4'b0100, 1, 1, 1});
        tbl.push_back('{0, 4'b1111, 1, 4'b1000, 1, 1, 2});
        tbl.push_back('{0, 4'b0000, 1, 4'b0000, 1, 1, 3});
        tbl.push_back('{0, 4'b0101, 0, 4'b0001, 0, 0, 0});
        tbl.push_back('{0, 4'b0101, 0, 4'b0100, 1, 1, 0});
        tbl.push_back('{0, 4'b0101, 0, 4'b0001, 1, 2, 0});
        tbl.push_back('{0, 4'b0101, 0, 4'b0100, 1, 3, 0});
        tbl.push_back('{0, 4'b0101, 0, 4'b0000, 1, 4, 0});
        tbl.push_back('{0, 4'b0101, 1, 4'b0000, 1, 4, 0});
        tbl.push_back('{0, 4'b0101, 1, 4'b0001, 1, 3, 2});
        tbl.push_back('{0, 4'b0000, 1, 4'b0000, 1, 3, 0});
        tbl.push_back('{0, 4'b0000, 1, 4'b0000, 1, 2, 2});
        tbl.push_back('{0, 4'b0000, 1, 4'b0000, 1, 1, 0});
        tbl.push_back('{0, 4'b0000, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{0, 4'b0001, 0, 4'b0001, 0, 0, 0});
        tbl.push_back('{0, 4'b0001, 0, 4'b0001, 1, 1, 0});
        tbl.push_back('{0, 4'b0001, 0, 4'b0001, 1, 2, 0});
        tbl.push_back('{1, 4'b0000, 0, 4'b0000, 1, 3, 0});
        tbl.push_back('{0, 4'b1111, 0, 4'b0001, 0, 0, 0});
        tbl.push_back('{1, 4'b0000, 0, 4'b0000, 1, 1, 0});
        tbl.push_back('{0, 4'b0000, 0, 4'b0000, 0, 0, 0});

        do_reset();

        // Idle after reset.
        out_rdy = 1'b1;
        repeat (3) model_cycle();

        // Single west write, addr 1234 / txnid 5.
        new_req(0);
        req[0].addr  = 64'h1234;
        req[0].txnid = 8'd5;
        repeat (3) model_cycle();

        if (!BYP) begin
            do_reset();
            for (int i = 0; i < 4; i++) begin
                in_addr[i]     = ADDR_W'(64'h100 + i);
                in_txnid[i]    = TXNID_W'(i);
                in_sideband[i] = '0;
                in_strb[i]     = '1;
                in_data[i]     = '0;
            end
            foreach (tbl[r]) begin
                rst     = tbl[r].rst;
                in_vld  = tbl[r].vld;
                out_rdy = tbl[r].ordy;
                #1;
                check($sformatf("vec%0d_in_rdy", r), in_rdy, tbl[r].exp_rdy);
                check($sformatf("vec%0d_out_vld", r), out_vld, tbl[r].exp_ov);
                check($sformatf("vec%0d_fifo_cnt", r), fifo_cnt, tbl[r].exp_cnt);
                if (tbl[r].exp_ov) begin
                    check($sformatf("vec%0d_src_dir", r), out_src_dir, tbl[r].exp_dir);
                    check($sformatf("vec%0d_addr", r), out_addr, 64'h100 + tbl[r].exp_dir);
                end
                @(posedge clk);
                @(negedge clk);
            end
            rst = 1'b0;
            do_reset();
        end

        // Two entries buffered, then ten cycles of simultaneous push and pop.
        do_reset();
        out_rdy = 1'b0;
        new_req(0);
        model_cycle();
        new_req(0);
        model_cycle();
        out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!vld[0]) new_req(0);
            model_cycle();
            check("steady_cnt", fifo_cnt, 2);
        end

`ifdef WR_BANK_DIR_ARB_BYPASS_EN
        // Empty FIFO, sink ready, east valid: same-cycle delivery without storage.
        do_reset();
        out_rdy = 1'b1;
        new_req(1);
        drive();
        #1;
        check("byp_out_vld", out_vld, 1'b1);
        check("byp_src_dir", out_src_dir, 2'd1);
        check("byp_addr", out_addr, req[1].addr);
        @(posedge clk);
        #1;
        check("byp_cnt", fifo_cnt, 0);
        @(negedge clk);
        vld[1] = 1'b0;
        rr = 2;
`endif

        // Randomized traffic with alternating sink pressure and occasional resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < 4; i++)
                    if (!vld[i] && $urandom_range(0, 1) == 1) new_req(i);
                out_rdy = ($urandom_range(0, 99) < (((cyc / 250) % 2 == 1) ? 85 : 30));
                model_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
